// File: rtl/qkd_frame_stat_accum_if.sv
// Event/handoff bundle between the sifting front end, the frame
// statistics accumulator and the error/leakage estimator.
interface qkd_frame_stat_accum_if #(
  parameter int N_W  = 21,
  parameter int NU_W = 25
);
  logic            i_evt_vld;
  logic [1:0]      i_evt_type;
  logic            i_evt_err;
  logic            i_frame_end;
  logic            i_est_busy;
  logic            o_start;
  logic [N_W-1:0]  o_nv;
  logic [NU_W-1:0] o_nu;
  logic [N_W-1:0]  o_no;
  logic [N_W-1:0]  o_mv;
  logic [N_W-1:0]  o_mo;
  logic            o_busy;
  logic            o_sat;
  logic            o_overrun;
  logic            o_timeout;

  modport master (
    output i_evt_vld, i_evt_type, i_evt_err,
    output i_frame_end, i_est_busy,
    input  o_start, o_nv, o_nu, o_no, o_mv, o_mo,
    input  o_busy, o_sat, o_overrun, o_timeout
  );

  modport slave (
    input  i_evt_vld, i_evt_type, i_evt_err,
    input  i_frame_end, i_est_busy,
    output o_start, o_nv, o_nu, o_no, o_mv, o_mo,
    output o_busy, o_sat, o_overrun, o_timeout
  );
endinterface

// File: rtl/qkd_frame_stat_accum.sv
// Per-frame decoy-class / error event counters with a held
// snapshot handed to the estimator via a start/busy handshake.
module qkd_frame_stat_accum #(
  parameter int          N_W     = 21,
  parameter int          NU_W    = 25,
  parameter logic [15:0] BUSY_TO = 16'd1024
) (
  input logic                   clk,
  input logic                   rst,
  qkd_frame_stat_accum_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  logic [1:0] rst_sync;
  logic       rst_i;

  // assert immediately, release two clocks after rst rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i = rst_sync[1];

  logic [N_W-1:0]  acc_nv, acc_no, acc_mv, acc_mo;
  logic [NU_W-1:0] acc_nu;
  logic            acc_sat;
  logic [N_W-1:0]  nx_nv, nx_no, nx_mv, nx_mo;
  logic [NU_W-1:0] nx_nu;
  logic            nx_sat;
  logic inc_nv, inc_no, inc_nu, inc_mv, inc_mo;
  logic hit_nv, hit_no, hit_nu, hit_mv, hit_mo;

  assign inc_nv = bus.i_evt_vld && (bus.i_evt_type == 2'd0);
  assign inc_no = bus.i_evt_vld && (bus.i_evt_type == 2'd1);
  assign inc_nu = bus.i_evt_vld && (bus.i_evt_type == 2'd2);
  assign inc_mv = inc_nv && bus.i_evt_err;
  assign inc_mo = inc_no && bus.i_evt_err;

  // an increment attempted at all-ones is a saturation hit
  assign hit_nv = inc_nv && (&acc_nv);
  assign hit_no = inc_no && (&acc_no);
  assign hit_nu = inc_nu && (&acc_nu);
  assign hit_mv = inc_mv && (&acc_mv);
  assign hit_mo = inc_mo && (&acc_mo);

  assign nx_nv = acc_nv + {{(N_W-1){1'b0}}, (inc_nv && !hit_nv)};
  assign nx_no = acc_no + {{(N_W-1){1'b0}}, (inc_no && !hit_no)};
  assign nx_nu = acc_nu + {{(NU_W-1){1'b0}}, (inc_nu && !hit_nu)};
  assign nx_mv = acc_mv + {{(N_W-1){1'b0}}, (inc_mv && !hit_mv)};
  assign nx_mo = acc_mo + {{(N_W-1){1'b0}}, (inc_mo && !hit_mo)};

  assign nx_sat = acc_sat | hit_nv | hit_no | hit_nu
                | hit_mv | hit_mo;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      acc_nv  <= '0;
      acc_no  <= '0;
      acc_nu  <= '0;
      acc_mv  <= '0;
      acc_mo  <= '0;
      acc_sat <= 1'b0;
    end else if (bus.i_frame_end) begin
      acc_nv  <= '0;
      acc_no  <= '0;
      acc_nu  <= '0;
      acc_mv  <= '0;
      acc_mo  <= '0;
      acc_sat <= 1'b0;
    end else begin
      acc_nv  <= nx_nv;
      acc_no  <= nx_no;
      acc_nu  <= nx_nu;
      acc_mv  <= nx_mv;
      acc_mo  <= nx_mo;
      acc_sat <= nx_sat;
    end
  end

  state_t      state;
  logic [15:0] tmo;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      tmo           <= '0;
      bus.o_start   <= 1'b0;
      bus.o_busy    <= 1'b0;
      bus.o_sat     <= 1'b0;
      bus.o_overrun <= 1'b0;
      bus.o_timeout <= 1'b0;
      bus.o_nv      <= '0;
      bus.o_nu      <= '0;
      bus.o_no      <= '0;
      bus.o_mv      <= '0;
      bus.o_mo      <= '0;
    end else begin
      bus.o_start   <= 1'b0;
      bus.o_overrun <= 1'b0;
      bus.o_timeout <= 1'b0;
      // a frame closing while the snapshot is held is dropped
      if (bus.i_frame_end && (state != IDLE))
        bus.o_overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.i_frame_end) begin
            bus.o_nv    <= nx_nv;
            bus.o_nu    <= nx_nu;
            bus.o_no    <= nx_no;
            bus.o_mv    <= nx_mv;
            bus.o_mo    <= nx_mo;
            bus.o_sat   <= nx_sat;
            bus.o_start <= 1'b1;
            bus.o_busy  <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          tmo   <= BUSY_TO;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.i_est_busy) begin
            state <= WAIT_LO;
          end else if (tmo <= 16'd1) begin
            tmo           <= '0;
            bus.o_timeout <= 1'b1;
            bus.o_busy    <= 1'b0;
            state         <= IDLE;
          end else begin
            tmo <= tmo - 16'd1;
          end
        end
        WAIT_LO: begin
          if (!bus.i_est_busy) begin
            bus.o_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qkd_frame_stat_accum.sv
// Bench for qkd_frame_stat_accum: a wide and a 4-bit instance share
// stimulus; snapshots are checked against per-frame event tallies.
module tb_qkd_frame_stat_accum;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  qkd_frame_stat_accum_if #(.N_W(21), .NU_W(25)) bus ();
  qkd_frame_stat_accum_if #(.N_W(4),  .NU_W(25)) bs ();

  qkd_frame_stat_accum #(
    .N_W(21), .NU_W(25), .BUSY_TO(16'd1024)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  qkd_frame_stat_accum #(
    .N_W(4), .NU_W(25), .BUSY_TO(16'd1024)
  ) dut_s (
    .clk(clk), .rst(rst), .bus(bs.slave)
  );

  int errs   = 0;
  int checks = 0;
  int cnt[5];
  int closed[5];
  int snap[5];
  bit rnd = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(int v, int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit exp_sat(int w);
    int m;
    m = (1 << w) - 1;
    return (snap[0] > m) || (snap[2] > m) || (snap[3] > m)
        || (snap[4] > m) || (snap[1] > ((1 << 25) - 1));
  endfunction

  task automatic clr_model();
    cnt = '{default: 0};
  endtask

  task automatic set_busy(bit b);
    bus.i_est_busy = b;
    bs.i_est_busy  = b;
  endtask

  task automatic drive(bit v, bit [1:0] t, bit e, bit fe);
    bus.i_evt_vld   = v;  bs.i_evt_vld   = v;
    bus.i_evt_type  = t;  bs.i_evt_type  = t;
    bus.i_evt_err   = e;  bs.i_evt_err   = e;
    bus.i_frame_end = fe; bs.i_frame_end = fe;
    @(posedge clk);
    if (v) begin
      case (t)
        2'd0: begin cnt[0]++; if (e) cnt[3]++; end
        2'd1: begin cnt[2]++; if (e) cnt[4]++; end
        2'd2: cnt[1]++;
        default: ;
      endcase
    end
    if (fe) begin
      closed = cnt;
      clr_model();
    end
    #1;
    bus.i_evt_vld   = 1'b0; bs.i_evt_vld   = 1'b0;
    bus.i_frame_end = 1'b0; bs.i_frame_end = 1'b0;
  endtask

  task automatic cyc(bit fe);
    bit       v;
    bit [1:0] t;
    bit       e;
    v = rnd && ($urandom_range(3) != 0);
    t = 2'($urandom_range(3));
    e = 1'($urandom_range(1));
    drive(v, t, e, fe);
  endtask

  task automatic check_ctl(string tag, bit st, bit bz, bit ov, bit to);
    chk({tag, " start"},     bus.o_start,   st);
    chk({tag, " busy"},      bus.o_busy,    bz);
    chk({tag, " overrun"},   bus.o_overrun, ov);
    chk({tag, " timeout"},   bus.o_timeout, to);
    chk({tag, " s.start"},   bs.o_start,    st);
    chk({tag, " s.busy"},    bs.o_busy,     bz);
  endtask

  task automatic check_out(string tag);
    chk({tag, " nv"},   bus.o_nv,  clamp(snap[0], 21));
    chk({tag, " nu"},   bus.o_nu,  clamp(snap[1], 25));
    chk({tag, " no"},   bus.o_no,  clamp(snap[2], 21));
    chk({tag, " mv"},   bus.o_mv,  clamp(snap[3], 21));
    chk({tag, " mo"},   bus.o_mo,  clamp(snap[4], 21));
    chk({tag, " sat"},  bus.o_sat, exp_sat(21));
    chk({tag, " s.nv"}, bs.o_nv,   clamp(snap[0], 4));
    chk({tag, " s.nu"}, bs.o_nu,   clamp(snap[1], 25));
    chk({tag, " s.no"}, bs.o_no,   clamp(snap[2], 4));
    chk({tag, " s.mv"}, bs.o_mv,   clamp(snap[3], 4));
    chk({tag, " s.mo"}, bs.o_mo,   clamp(snap[4], 4));
    chk({tag, " s.sat"}, bs.o_sat, exp_sat(4));
  endtask

  task automatic check_zero(string tag);
    check_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    snap = '{default: 0};
    check_out(tag);
  endtask

  task automatic take(string tag);
    cyc(1'b1);
    snap = closed;
    check_ctl(tag, 1'b1, 1'b1, 1'b0, 1'b0);
    check_out(tag);
  endtask

  task automatic est_run(string tag, int dly, int len);
    cyc(1'b0);
    check_ctl({tag, " post"}, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (dly) cyc(1'b0);
    set_busy(1'b1);
    repeat (len) cyc(1'b0);
    check_ctl({tag, " held"}, 1'b0, 1'b1, 1'b0, 1'b0);
    check_out({tag, " held"});
    set_busy(1'b0);
    cyc(1'b0);
    check_ctl({tag, " done"}, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out({tag, " done"});
  endtask

  initial begin
    bus.i_evt_vld = 1'b0; bus.i_evt_type = 2'd0; bus.i_evt_err = 1'b0;
    bus.i_frame_end = 1'b0; bus.i_est_busy = 1'b0;
    bs.i_evt_vld = 1'b0; bs.i_evt_type = 2'd0; bs.i_evt_err = 1'b0;
    bs.i_frame_end = 1'b0; bs.i_est_busy = 1'b0;
    clr_model();

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    repeat (4) cyc(1'b0);
    clr_model();

    // directed frame from the plan
    for (int i = 0; i < 10; i++)  drive(1'b1, 2'd0, (i < 3), 1'b0);
    for (int i = 0; i < 20; i++)  drive(1'b1, 2'd1, (i < 5), 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b1, 2'd2, (i < 7), 1'b0);
    for (int i = 0; i < 4; i++)   drive(1'b1, 2'd3, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    snap = closed;
    check_ctl("f1", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out("f1");
    chk("f1 nv=10",  bus.o_nv, 10);
    chk("f1 nu=100", bus.o_nu, 100);
    chk("f1 mo=5",   bus.o_mo, 5);
    est_run("f1", 1, 50);

    // event coincident with frame end is part of the closing frame
    drive(1'b1, 2'd1, 1'b1, 1'b1);
    snap = closed;
    check_ctl("same", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out("same");
    chk("same no=1", bus.o_no, 1);
    chk("same mo=1", bus.o_mo, 1);
    est_run("same", 0, 3);
    take("empty");
    est_run("empty", 0, 2);

    // overrun while estimator busy
    rnd = 1'b1;
    repeat (60) cyc(1'b0);
    take("ov1");
    cyc(1'b0);
    set_busy(1'b1);
    repeat (10) cyc(1'b0);
    cyc(1'b1);
    check_ctl("ov", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ov s.overrun", bs.o_overrun, 1'b1);
    check_out("ov");
    cyc(1'b0);
    check_ctl("ov after", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (38) cyc(1'b0);
    set_busy(1'b0);
    cyc(1'b0);
    check_ctl("ov done", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("ov done");
    repeat (30) cyc(1'b0);
    take("ov3");
    est_run("ov3", 1, 20);

    // estimator never responds
    repeat (25) cyc(1'b0);
    take("to");
    repeat (1024) cyc(1'b0);
    check_ctl("to pre", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0);
    check_ctl("to", 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("to");
    take("to next");
    check_ctl("to next2", 1'b1, 1'b1, 1'b0, 1'b0);
    est_run("to next", 2, 8);

    // saturation of the 4-bit instance, then clean frame
    rnd = 1'b0;
    for (int i = 0; i < 17; i++) drive(1'b1, 2'd0, 1'b0, 1'b0);
    take("sat");
    chk("sat s.nv=15", bs.o_nv, 15);
    chk("sat s.sat=1", bs.o_sat, 1'b1);
    est_run("sat", 0, 4);
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    take("unsat");
    chk("unsat s.nv=2", bs.o_nv, 2);
    chk("unsat s.sat=0", bs.o_sat, 1'b0);
    est_run("unsat", 0, 4);

    // random frames and estimator timing
    rnd = 1'b1;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(80, 20)) cyc(1'b0);
      take("rnd");
      est_run("rnd", $urandom_range(3), $urandom_range(30, 5));
    end

    // async reset while estimator is busy
    repeat (15) cyc(1'b0);
    take("rs");
    cyc(1'b0);
    set_busy(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_zero("rs async");
    set_busy(1'b0);
    rnd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0);
      chk("rs no start", bus.o_start, 1'b0);
    end
    clr_model();
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd2, 1'b0, 1'b0);
    take("rs fresh");
    chk("rs fresh nu=5", bus.o_nu, 5);
    est_run("rs fresh", 0, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/qkd_frame_stat_accum.md
# qkd_frame_stat_accum

Per-frame detection-statistics accumulator upstream of the error/leakage estimator. It counts sifted detection events by decoy class and bit-error flag over one key frame. At frame end it snapshots the counts into stable output registers and issues a one-cycle start to the estimator. It holds the snapshot until the estimator finishes, while already accumulating the next frame.

## Interface
- `N_W`, 21, width of vacuum/decoy event and error counters (`nv`, `no`, `mv`, `mo`)
- `NU_W`, 25, width of signal event counter (`nu`)
- `BUSY_TO`, 16'd1024, cycles to wait for estimator busy to rise after start before flagging timeout

- `clk`  in  1  single system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_evt_vld`  in  1  one sifted detection event this cycle
- `i_evt_type`  in  2  0 = vacuum, 1 = decoy, 2 = signal, 3 = reserved (ignored)
- `i_evt_err`  in  1  event's sifted bit disagrees (error); qualified by `i_evt_vld`
- `i_frame_end`  in  1  one-cycle pulse, closes current frame
- `i_est_busy`  in  1  estimator busy (registered on estimator side)
- `o_start`  out  1  one-cycle start pulse to estimator
- `o_nv`  out  N_W  vacuum event count of handed-off frame
- `o_nu`  out  NU_W  signal event count
- `o_no`  out  N_W  decoy event count
- `o_mv`  out  N_W  vacuum error count
- `o_mo`  out  N_W  decoy error count
- `o_busy`  out  1  snapshot held, estimator not yet done
- `o_sat`  out  1  sticky per snapshot: any counter of that frame saturated
- `o_overrun`  out  1  one-cycle pulse: frame dropped because previous snapshot still held
- `o_timeout`  out  1  one-cycle pulse: estimator busy never rose within `BUSY_TO`

## Operation
- Accumulate counters `acc_nv/nu/no/mv/mo` plus `acc_sat`.
  - Event type 0 increments `nv`; if err, also `mv`.
  - Type 1 increments `no`; if err, also `mo`.
  - Type 2 increments `nu` only; its err flag is ignored.
  - Type 3 changes nothing.
- Counters saturate at all-ones. An increment attempted at max leaves the value and sets `acc_sat`.
- An event in the same cycle as `i_frame_end` belongs to the closing frame. The snapshot includes it, and the accumulators restart at 0 the next cycle.
- Output FSM states:
  - IDLE
    - On `i_frame_end`: copy accumulators (including the same-cycle event) into output registers and `o_sat`; clear accumulators; go to START.
  - START
    - `o_start` = 1 for exactly this cycle; `o_busy` = 1; load timeout counter; go to WAIT_HI.
  - WAIT_HI
    - If `i_est_busy` = 1, go to WAIT_LO.
    - Else decrement the timeout counter. At 0, pulse `o_timeout` and go to IDLE.
  - WAIT_LO
    - When `i_est_busy` = 0, go to IDLE. `o_busy` drops on entry to IDLE.
- Outputs `o_nv..o_mo` and `o_sat` are stable from START until the next snapshot. They are never modified outside the IDLE→START transfer.
- `i_frame_end` while the FSM is not IDLE:
  - Pulse `o_overrun`.
  - Clear accumulators without snapshot; the frame is lost.
  - Output registers are untouched.
- Accumulation continues in every state.

## Timing
- Reset (`rst` = 0, async):
  - All counters and output registers = 0.
  - `o_start`, `o_busy`, `o_sat`, `o_overrun`, `o_timeout` = 0.
  - FSM = IDLE.
  - Release is synchronised internally (2-flop deassert).
- Reset mid-frame or mid-handoff discards everything. No start is issued after reset until a new `i_frame_end`.
- Latency:
  - `i_frame_end` at cycle T (FSM IDLE) → outputs valid and `o_start` = 1 at T+1.
  - Estimator busy is expected at T+2 or later.
- Minimum frame-to-frame spacing without overrun = estimator processing time + 3 cycles.
- `o_start` never asserts while `o_busy` was already 1 in the previous cycle.
- `o_overrun` and `o_timeout` are single-cycle and can coincide with accumulation but never with `o_start`.

## Test plan
- Reset, then 10 vacuum (3 err), 20 decoy (5 err), 100 signal (7 err), 4 type-3 events, then `i_frame_end` → `o_start` one cycle later with nv=10, no=20, nu=100, mv=3, mo=5, `o_sat`=0.
- Event type 1 with err in the same cycle as `i_frame_end` → included in snapshot (no=1, mo=1); next frame starts from 0.
- Estimator model raises busy 2 cycles after start for 50 cycles; second `i_frame_end` during busy → `o_overrun` pulse, outputs unchanged. Third frame after busy falls → new snapshot and start.
- Estimator never raises busy → `o_timeout` at start+`BUSY_TO`+1, FSM IDLE, next frame end is accepted.
- With `N_W` = 4, 17 vacuum events → nv=15, `o_sat`=1; the following frame with 2 events → nv=2, `o_sat`=0.
- Assert `rst` low during WAIT_LO → all outputs 0 immediately (async); after release, no start until a fresh `i_frame_end`.
